// File: rtl/axi_lite_read_responder.sv
// AXI4-Lite read-side slave engine.
// Accepts AR requests, decodes them into a word index, strobes the user
// register space, and returns {rdata, rresp} in acceptance order through a
// response FIFO. Handshake semantics on both channels: a transfer happens in
// a cycle where valid and ready are both high at the rising edge. Once this
// block raises rvalid it keeps rvalid/rdata/rresp stable until rready.
// The credit counter covers every read from AR acceptance until its R beat,
// so the FIFO can never be pushed while full.
module axi_lite_read_responder #(
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int AXI_RDATA_WIDTH = 32,
    parameter int NREGS           = 16,
    parameter int DEPTH           = 4,
    parameter int READ_LATENCY    = 1,
    localparam int IDX_W          = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int CNT_W          = $clog2(DEPTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       arvalid,
    output logic                       arready,
    input  logic [AXI_ADDR_WIDTH-1:0]  araddr,
    input  logic [2:0]                 arprot,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [AXI_RDATA_WIDTH-1:0] rdata,
    output logic [1:0]                 rresp,
    output logic                       rd_en,
    output logic [IDX_W-1:0]           rd_index,
    input  logic [AXI_RDATA_WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0]           outstanding
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Credit counter
    logic [CNT_W-1:0] outstanding_q, outstanding_d;

    // Tag pipeline: one {valid, resp} slot per cycle of read latency
    logic [READ_LATENCY-1:0]   pipe_vld_q, pipe_vld_d;
    logic [2*READ_LATENCY-1:0] pipe_resp_q, pipe_resp_d;

    // Response FIFO
    logic [AXI_RDATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [1:0]                 fifo_resp_q [DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           fifo_cnt_q, fifo_cnt_d;

    logic                       ar_hs;
    logic                       r_hs;
    logic [AXI_ADDR_WIDTH-1:0]  word_addr;
    logic [1:0]                 dec_resp;
    logic                       push;
    logic                       pop;
    logic [1:0]                 push_resp;
    logic [AXI_RDATA_WIDTH-1:0] push_data;

    // arprot carries no meaning for this register space.
    logic unused_arprot;
    assign unused_arprot = ^arprot;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends only on the registered credit count and reset.
    assign arready = (outstanding_q < CNT_W'(DEPTH)) && !reset;
    assign ar_hs   = arvalid && arready;
    assign rvalid  = (fifo_cnt_q != '0);
    assign r_hs    = rvalid && rready;
    assign pop     = r_hs;

    // Address decode: misalignment wins over range errors.
    always_comb begin
        word_addr = araddr >> 2;
        if (araddr[1:0] != 2'b00) begin
            dec_resp = RESP_SLVERR;
        end else if (word_addr >= AXI_ADDR_WIDTH'(NREGS)) begin
            dec_resp = RESP_DECERR;
        end else begin
            dec_resp = RESP_OKAY;
        end
    end

    assign rd_en    = ar_hs && (dec_resp == RESP_OKAY);
    assign rd_index = word_addr[IDX_W-1:0];

    // The last tag stage lines up with the cycle rd_data is valid.
    assign push      = pipe_vld_q[READ_LATENCY-1];
    assign push_resp = pipe_resp_q[2*READ_LATENCY-1 -: 2];
    assign push_data = (push_resp == RESP_OKAY) ? rd_data : '0;

    // Head of FIFO drives the R channel; idle outputs read as zero.
    assign rdata       = rvalid ? fifo_data_q[rd_ptr_q] : '0;
    assign rresp       = rvalid ? fifo_resp_q[rd_ptr_q] : RESP_OKAY;
    assign outstanding = outstanding_q;

    // Next-state for credits, tag pipe shift and FIFO occupancy.
    always_comb begin
        outstanding_d = outstanding_q;
        if (ar_hs && !r_hs) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!ar_hs && r_hs) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        pipe_vld_d       = pipe_vld_q << 1;
        pipe_vld_d[0]    = ar_hs;
        pipe_resp_d      = pipe_resp_q << 2;
        pipe_resp_d[1:0] = dec_resp;

        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        end
    end

    // Control state; reset drops every in-flight read without a response.
    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding_q <= '0;
            pipe_vld_q    <= '0;
            pipe_resp_q   <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            pipe_vld_q    <= pipe_vld_d;
            pipe_resp_q   <= pipe_resp_d;
            fifo_cnt_q    <= fifo_cnt_d;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // FIFO storage; entries are qualified by the occupancy count, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_resp_q[wr_ptr_q] <= push_resp;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && (fifo_cnt_q == CNT_W'(DEPTH))));

    a_credit_bound: assert property (@(posedge clock) disable iff (reset)
        outstanding_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_axi_lite_read_responder.sv
// Bench for axi_lite_read_responder: two configurations (L=1/DEPTH=4 and
// L=4/DEPTH=6) run the same directed phases plus a random sweep, checked
// against a transaction-level model (each accepted read becomes visible
// L+1 cycles after acceptance, returned oldest-first).
module tb_axi_lite_read_responder;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int NREGS = 16;
    localparam int IW    = $clog2(NREGS);

    logic clk = 1'b0;
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;

    // Clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int L  = (g == 0) ? 1 : 4;
        localparam int D  = (g == 0) ? 4 : 6;
        localparam int CW = $clog2(D + 1);
        localparam logic [AW-1:0] ERR_ADDRS [7] =
            '{16'h0002, 16'h0010, 16'h0040, 16'h0041, 16'h003C, 16'hFFFC, 16'h0001};

        logic          reset;
        logic          arvalid;
        logic          arready;
        logic [AW-1:0] araddr;
        logic [2:0]    arprot;
        logic          rvalid;
        logic          rready;
        logic [DW-1:0] rdata;
        logic [1:0]    rresp;
        logic          rd_en;
        logic [IW-1:0] rd_index;
        logic [DW-1:0] rd_data;
        logic [CW-1:0] outstanding;

        logic [DW-1:0]   regs [NREGS];
        logic [DW*L-1:0] dl;
        logic [DW+1:0]   exp_q [$];
        int              rdy_q [$];
        int              cyc = 0;

        axi_lite_read_responder #(
            .AXI_ADDR_WIDTH (AW),
            .AXI_RDATA_WIDTH(DW),
            .NREGS          (NREGS),
            .DEPTH          (D),
            .READ_LATENCY   (L)
        ) u_dut (
            .clock      (clk),
            .reset      (reset),
            .arvalid    (arvalid),
            .arready    (arready),
            .araddr     (araddr),
            .arprot     (arprot),
            .rvalid     (rvalid),
            .rready     (rready),
            .rdata      (rdata),
            .rresp      (rresp),
            .rd_en      (rd_en),
            .rd_index   (rd_index),
            .rd_data    (rd_data),
            .outstanding(outstanding)
        );

        // User register space: data valid L cycles after the strobe, junk otherwise.
        always @(posedge clk) begin
            dl <= (dl << DW) | (DW*L)'(rd_en ? regs[rd_index] : DW'($urandom));
        end
        assign rd_data = dl[DW*L-1 -: DW];

        // Expected {rresp, rdata} for an address, straight from the decode rules.
        function automatic logic [DW+1:0] ref_beat(input logic [AW-1:0] a);
            int ai;
            ai = int'(a);
            if (ai % 4 != 0) return {2'b10, DW'(0)};
            if (ai / 4 >= NREGS) return {2'b11, DW'(0)};
            return {2'b00, regs[IW'(ai / 4)]};
        endfunction

        // Scoreboard: every cycle compare ready/valid/data with the model.
        always @(negedge clk) begin
            logic          exp_ar;
            logic          exp_rv;
            logic          ok;
            logic [DW+1:0] beat;
            cyc++;
            if (reset === 1'b1) begin
                check_val("arready_in_reset", 64'(arready), 64'(0));
                check_val("rd_en_in_reset", 64'(rd_en), 64'(0));
                exp_q.delete();
                rdy_q.delete();
            end else begin
                exp_ar = (exp_q.size() < D);
                exp_rv = 1'b0;
                if (exp_q.size() > 0) exp_rv = (rdy_q[0] <= cyc);
                beat = ref_beat(araddr);
                ok   = (beat[DW+1:DW] == 2'b00);
                check_val("arready", 64'(arready), 64'(exp_ar));
                check_val("outstanding", 64'(outstanding), 64'(exp_q.size()));
                check_val("out_le_depth", 64'(outstanding <= CW'(D)), 64'(1));
                check_val("rvalid", 64'(rvalid), 64'(exp_rv));
                if (exp_rv) begin
                    check_val("rdata", 64'(rdata), 64'(exp_q[0][DW-1:0]));
                    check_val("rresp", 64'(rresp), 64'(exp_q[0][DW+1:DW]));
                end
                check_val("rd_en", 64'(rd_en), 64'(arvalid && exp_ar && ok));
                if (arvalid && exp_ar && ok) begin
                    check_val("rd_index", 64'(rd_index), 64'(araddr >> 2));
                end
                if (exp_rv && rready) begin
                    void'(exp_q.pop_front());
                    void'(rdy_q.pop_front());
                end
                if (arvalid && exp_ar) begin
                    exp_q.push_back(beat);
                    rdy_q.push_back(cyc + L + 1);
                end
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        // Present one address and hold it until accepted (bounded).
        task automatic ar_send(input logic [AW-1:0] a, output int cycles);
            logic hs;
            arvalid = 1'b1;
            araddr  = a;
            arprot  = 3'($urandom);
            cycles  = 0;
            do begin
                @(negedge clk);
                hs = arready;
                tick();
                cycles++;
            end while (!hs && cycles < 100);
            if (!hs) check_val("ar_timeout", 64'(0), 64'(1));
        endtask

        task automatic wait_drain(input string tag);
            int n;
            n = 0;
            while ((outstanding != '0 || rvalid) && n < 200) begin
                tick();
                n++;
            end
            check_val(tag, 64'(outstanding != '0 || rvalid), 64'(0));
        endtask

        // Driver: directed phases, then random sweep.
        initial begin
            int   cy, lat, acc, tot, n;
            logic hs;
            reset   = 1'b1;
            arvalid = 1'b0;
            araddr  = '0;
            arprot  = '0;
            rready  = 1'b0;
            foreach (regs[i]) regs[i] = $urandom;
            regs[3] = 32'hDEADBEEF;
            repeat (3) tick();
            reset = 1'b0;

            // First cycle out of reset
            @(negedge clk);
            check_val("rst_arready", 64'(arready), 64'(1));
            check_val("rst_rvalid", 64'(rvalid), 64'(0));
            check_val("rst_rdata", 64'(rdata), 64'(0));
            check_val("rst_rresp", 64'(rresp), 64'(0));
            check_val("rst_outstanding", 64'(outstanding), 64'(0));
            tick();

            // Single read of word 3
            rready = 1'b1;
            ar_send(16'h000C, cy);
            arvalid = 1'b0;
            lat = 1;
            while (lat < 20) begin
                @(negedge clk);
                if (rvalid) break;
                tick();
                lat++;
            end
            check_val("single_latency", 64'(lat), 64'(L + 1));
            check_val("single_rdata", 64'(rdata), 64'(32'hDEADBEEF));
            check_val("single_rresp", 64'(rresp), 64'(0));
            tick();
            wait_drain("single_drain");

            // Streaming 16 back-to-back reads
            tot = 0;
            for (int i = 0; i < 16; i++) begin
                ar_send(AW'(i * 4), cy);
                tot += cy;
            end
            arvalid = 1'b0;
            check_val("stream_cycles", 64'(tot), 64'(16));
            wait_drain("stream_drain");

            // Backpressure: D+2 requests against a stalled R channel
            rready  = 1'b0;
            acc     = 0;
            arvalid = 1'b1;
            araddr  = '0;
            repeat (D + L + 6) begin
                @(negedge clk);
                hs = arready;
                tick();
                if (hs) begin
                    acc++;
                    araddr = AW'(acc * 4);
                end
            end
            check_val("bp_accepted", 64'(acc), 64'(D));
            check_val("bp_outstanding", 64'(outstanding), 64'(D));
            check_val("bp_arready", 64'(arready), 64'(0));
            check_val("bp_rvalid", 64'(rvalid), 64'(1));
            rready = 1'b1;
            n = 0;
            while (acc < D + 2 && n < 100) begin
                @(negedge clk);
                hs = arready;
                tick();
                n++;
                if (hs) begin
                    acc++;
                    araddr = AW'(acc * 4);
                end
            end
            arvalid = 1'b0;
            check_val("bp_total", 64'(acc), 64'(D + 2));
            wait_drain("bp_drain");

            // Error decodes interleaved with legal reads
            for (int i = 0; i < 7; i++) ar_send(ERR_ADDRS[i], cy);
            arvalid = 1'b0;
            wait_drain("err_drain");

            // Reset with reads pending
            rready = 1'b0;
            for (int i = 0; i < 3; i++) ar_send(AW'((i + 5) * 4), cy);
            arvalid = 1'b0;
            repeat (L + 2) tick();
            check_val("mid_rvalid_before", 64'(rvalid), 64'(1));
            reset = 1'b1;
            tick();
            reset = 1'b0;
            @(negedge clk);
            check_val("mid_rvalid_after", 64'(rvalid), 64'(0));
            check_val("mid_outstanding", 64'(outstanding), 64'(0));
            check_val("mid_arready", 64'(arready), 64'(1));
            tick();
            rready = 1'b1;
            ar_send(16'h0014, cy);
            arvalid = 1'b0;
            wait_drain("mid_drain");

            // Random sweep with random rready
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                hs = arvalid && arready;
                tick();
                if (hs || !arvalid) begin
                    arvalid = ($urandom_range(0, 3) != 0);
                    arprot  = 3'($urandom);
                    case ($urandom_range(0, 9))
                        0:       araddr = {AW'($urandom) & ~AW'(3)} | AW'($urandom_range(1, 3));
                        1:       araddr = AW'($urandom_range(NREGS, 4000) * 4);
                        default: araddr = AW'($urandom_range(0, NREGS - 1) * 4);
                    endcase
                end
                rready = ($urandom_range(0, 2) != 0);
            end
            arvalid = 1'b0;
            rready  = 1'b1;
            wait_drain("sweep_drain");
            done_cnt++;
        end
    end

    // Summary once both configurations finish (bounded).
    initial begin
        int n;
        n = 0;
        while (done_cnt < 2 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check_val("both_done", 64'(done_cnt), 64'(2));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
